// File: rtl/cr_bmu_pmp_gate_if.sv
// Request/response channel between a requester, the PMP gate and the bus
// interface. The gate uses the slave view and the environment the master view.
interface cr_bmu_pmp_gate_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // requester side
  logic              req_vld;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic              req_rdy;
  logic              pmp_acc_deny;
  logic              rsp_vld;
  logic              rsp_err;
  logic              rsp_deny;
  logic [DATA_W-1:0] rsp_rdata;
  // bus side
  logic              bus_req_vld;
  logic [ADDR_W-1:0] bus_req_addr;
  logic              bus_req_write;
  logic              bus_req_rdy;
  logic              bus_rsp_vld;
  logic              bus_rsp_err;
  logic [DATA_W-1:0] bus_rsp_rdata;

  modport slave (
    input  req_vld, req_addr, req_write, pmp_acc_deny,
    input  bus_req_rdy, bus_rsp_vld, bus_rsp_err, bus_rsp_rdata,
    output req_rdy, rsp_vld, rsp_err, rsp_deny, rsp_rdata,
    output bus_req_vld, bus_req_addr, bus_req_write
  );

  modport master (
    output req_vld, req_addr, req_write, pmp_acc_deny,
    output bus_req_rdy, bus_rsp_vld, bus_rsp_err, bus_rsp_rdata,
    input  req_rdy, rsp_vld, rsp_err, rsp_deny, rsp_rdata,
    input  bus_req_vld, bus_req_addr, bus_req_write
  );
endinterface

// File: rtl/cr_bmu_pmp_gate.sv
// BMU per-bus PMP gate: forwards permitted transfers to the bus, answers
// denied ones locally with an access-fault response after DENY_LAT cycles,
// and keeps a small fault log (sticky flag, last address, saturating count).
// DENY_LAT must lie in 1..4.
module cr_bmu_pmp_gate #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DENY_LAT = 2
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  cr_bmu_pmp_gate_if.slave  bif,
  input  logic              deny_clr,
  output logic              deny_vld,
  output logic [ADDR_W-1:0] deny_addr,
  output logic [7:0]        deny_cnt
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, BUS_WAIT, DENY_WAIT} state_t;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic              deny;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  state_t     state;
  logic [CNT_W-1:0] cnt;
  rsp_t       rsp_q;
  logic       idle;
  logic       deny_acc;

  assign idle     = (state == IDLE);
  assign deny_acc = idle & bif.req_vld & bif.pmp_acc_deny;

  // Handshake outputs are purely state + inputs so they hold in the reset cycle.
  assign bif.req_rdy       = idle & (bif.pmp_acc_deny | bif.bus_req_rdy);
  assign bif.bus_req_vld   = idle & bif.req_vld & ~bif.pmp_acc_deny;
  assign bif.bus_req_addr  = bif.req_addr;
  assign bif.bus_req_write = bif.req_write;

  assign bif.rsp_vld   = rsp_q.vld;
  assign bif.rsp_err   = rsp_q.err;
  assign bif.rsp_deny  = rsp_q.deny;
  assign bif.rsp_rdata = rsp_q.rdata;

  // Transfer FSM with registered response. The synthetic response is
  // registered on the edge where the countdown hits zero, so it appears
  // exactly DENY_LAT cycles after acceptance with the state already IDLE.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state <= IDLE;
      cnt   <= '0;
      rsp_q <= '0;
    end else begin
      rsp_q <= '0;
      case (state)
        IDLE: begin
          if (bif.req_vld && bif.pmp_acc_deny) begin
            if (DENY_LAT <= 1) begin
              rsp_q <= '{vld: 1'b1, err: 1'b1, deny: 1'b1, rdata: '0};
            end else begin
              state <= DENY_WAIT;
              cnt   <= CNT_W'(DENY_LAT - 1);
            end
          end else if (bif.req_vld && bif.bus_req_rdy) begin
            state <= BUS_WAIT;
          end
        end
        BUS_WAIT: begin
          if (bif.bus_rsp_vld) begin
            rsp_q <= '{vld: 1'b1, err: bif.bus_rsp_err, deny: 1'b0,
                       rdata: bif.bus_rsp_rdata};
            state <= IDLE;
          end
        end
        DENY_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            rsp_q <= '{vld: 1'b1, err: 1'b1, deny: 1'b1, rdata: '0};
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fault log; a denial in the same cycle as a clear takes priority.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      deny_vld  <= 1'b0;
      deny_addr <= '0;
      deny_cnt  <= '0;
    end else if (deny_acc) begin
      deny_vld  <= 1'b1;
      deny_addr <= bif.req_addr;
      if (deny_clr)
        deny_cnt <= 8'd1;
      else if (deny_cnt != 8'hFF)
        deny_cnt <= deny_cnt + 8'd1;
    end else if (deny_clr) begin
      deny_vld <= 1'b0;
      deny_cnt <= '0;
    end
  end

endmodule

// File: doc/cr_bmu_pmp_gate.md
# cr_bmu_pmp_gate

Per-bus request gate in the BMU that consumes the PMP deny verdict (`pmp_bmu_ibus_acc_deny` or `pmp_bmu_dbus_acc_deny`) and decides whether a requester transfer reaches the bus interface. A permitted request is forwarded, and its bus response is registered back to the requester. A denied request is never issued to the bus; the gate synthesises an access-fault response and logs the faulting address. The gate is instantiated once for the IFU side and once for the LSU side.

## Interface

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, read data width
- DENY_LAT, 2, cycles from denied acceptance to the synthetic response; legal range 1..4

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  reset; synchronous, active-high
- req_vld  in  1  requester transfer valid
- req_addr  in  ADDR_W  transfer address
- req_write  in  1  1 = store, 0 = load/fetch
- req_rdy  out  1  gate accepts the transfer this cycle
- pmp_acc_deny  in  1  PMP verdict for `req_addr`; combinational, same cycle as `req_vld`
- bus_req_vld  out  1  forwarded transfer valid
- bus_req_addr  out  ADDR_W  forwarded address; equals `req_addr`
- bus_req_write  out  1  forwarded direction; equals `req_write`
- bus_req_rdy  in  1  bus interface accepts the forwarded transfer
- bus_rsp_vld  in  1  bus response valid
- bus_rsp_err  in  1  bus error
- bus_rsp_rdata  in  DATA_W  bus read data
- rsp_vld  out  1  response to requester; one-cycle pulse, always accepted
- rsp_err  out  1  error response
- rsp_deny  out  1  error caused by PMP denial
- rsp_rdata  out  DATA_W  read data; 0 on denial
- deny_clr  in  1  clears the fault log
- deny_vld  out  1  sticky: at least one denial logged since reset or clear
- deny_addr  out  ADDR_W  address of the most recent denial
- deny_cnt  out  8  saturating count of denials

## Operation

- State machine:
  - IDLE: the only state that accepts requests.
  - BUS_WAIT: a forwarded transfer is outstanding.
  - DENY_WAIT: a synthetic response is pending; counts down from DENY_LAT.
- At most one transfer is outstanding.
- Combinational outputs:
  - `req_rdy = IDLE & (pmp_acc_deny | bus_req_rdy)`
  - `bus_req_vld = IDLE & req_vld & ~pmp_acc_deny`. A denied address never appears on the bus.
- Transitions:
  - IDLE → BUS_WAIT on `req_vld & ~pmp_acc_deny & bus_req_rdy`.
  - IDLE → DENY_WAIT on `req_vld & pmp_acc_deny`. The down-counter loads DENY_LAT-1.
  - BUS_WAIT: when `bus_rsp_vld` is sampled, the next cycle drives `rsp_vld=1`, `rsp_err=bus_rsp_err`, `rsp_deny=0`, and `rsp_rdata=bus_rsp_rdata`, then returns to IDLE.
  - DENY_WAIT: when the counter reaches 0, the next cycle drives `rsp_vld=1`, `rsp_err=1`, `rsp_deny=1`, and `rsp_rdata=0`, then returns to IDLE.
- Response path: `rsp_*` are registered. `rsp_err`, `rsp_deny` and `rsp_rdata` are 0 whenever `rsp_vld=0`.
- `bus_rsp_vld` outside BUS_WAIT is ignored.
- Fault log, updated on each denied acceptance:
  - `deny_addr <= req_addr`
  - `deny_vld <= 1`
  - `deny_cnt` increments and saturates at 255.
- `deny_clr` zeroes `deny_vld` and `deny_cnt`; `deny_addr` holds its value.
- `deny_clr` in the same cycle as a denied acceptance: the new denial wins, giving `deny_vld=1`, `deny_cnt=1`, and `deny_addr` updated.

## Timing

- Reset values: all `rsp_*`=0, `deny_vld`=0, `deny_cnt`=0, `deny_addr`=0, state IDLE.
- `req_rdy` and `bus_req_vld` depend on state and inputs only, so they are valid in the reset cycle.
- Latency, permitted transfer: `rsp_vld` is asserted exactly 1 cycle after `bus_rsp_vld`.
- Latency, denied transfer: `rsp_vld` is asserted exactly DENY_LAT cycles after the acceptance cycle.
- Back-to-back requests: a new request can be accepted in the same cycle `rsp_vld` is high, because the state is already IDLE.
- `req_vld` held while `bus_req_rdy=0` and not denied: `req_rdy=0`, `bus_req_vld=1`, and all request fields must stay stable.
- Reset mid-transfer (BUS_WAIT or DENY_WAIT): no response is delivered, the fault log clears, and a late `bus_rsp_vld` after reset is ignored.
- `pmp_acc_deny` is only sampled when `req_vld=1`.

## Test plan

- Permitted load:
  - Stimulus: `req_vld=1`, `req_addr=0x2000_0010`, deny=0, `bus_req_rdy=1`; 3 cycles later `bus_rsp_vld=1`, `rdata=0xCAFE_F00D`.
  - Required: `bus_req_vld` asserted in the request cycle; one cycle after `bus_rsp_vld`, `rsp_vld=1`, `rsp_err=0`, `rsp_rdata=0xCAFE_F00D`.
- Denied store:
  - Stimulus: `req_addr=0x4000_0000`, `req_write=1`, deny=1, DENY_LAT=2.
  - Required: `bus_req_vld` never asserted; `rsp_vld`, `rsp_err` and `rsp_deny` all 1 exactly 2 cycles after acceptance; `deny_addr=0x4000_0000`, `deny_cnt=1`, `deny_vld=1`.
- Bus back-pressure:
  - Stimulus: permitted request with `bus_req_rdy=0` for 4 cycles, then 1.
  - Required: `req_rdy=0` for 4 cycles; acceptance on the 5th.
- Counter saturation:
  - Stimulus: 260 consecutive denied requests.
  - Required: `deny_cnt=255`; `deny_addr` equals the last address.
- Simultaneous events:
  - Stimulus: `deny_clr` asserted in the same cycle as a denied acceptance.
  - Required: `deny_cnt=1`, `deny_vld=1`.
  - Stimulus: `deny_clr` alone.
  - Required: `deny_cnt=0`, `deny_vld=0`, `deny_addr` unchanged.
- Reset mid-transfer:
  - Stimulus: `cpurst` asserted during BUS_WAIT, then `bus_rsp_vld` one cycle after reset deasserts.
  - Required: no `rsp_vld`; state IDLE; the next request is accepted normally.
